gate_arbiter: RTL

Sequencer and arbiter for the single physical parking gate shared by an entry lane and an exit lane. Accepts already-validated requests from both lanes, grants the gate to one at a time with round-robin fairness, drives the actuator open/close handshake, and tracks lot occupancy against a fixed capacity. Sits between the per-lane PIN controllers and the gate actuator.

---
 rtl/gate_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gate_arbiter.sv
`default_nettype none
// ============================================================================
// gate_arbiter : round-robin owner of the shared parking gate + occupancy
// Rev 1.0
// ============================================================================
module gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int PASS_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             vehicle_passed,
  input  logic             gate_ack,
  output logic             open_cmd,
  output logic             close_cmd,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             fault
);

  localparam int TMO_MAX = (ACK_TIMEOUT > PASS_TIMEOUT) ? ACK_TIMEOUT : PASS_TIMEOUT;
  localparam int TMO_W   = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
  localparam logic [TMO_W-1:0] c_ack_last  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] c_pass_last = TMO_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_capacity  = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_OPEN_WAIT  = 3'd1,
    S_PASS_WAIT  = 3'd2,
    S_CLOSE_WAIT = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  state_t           r_state;
  logic [TMO_W-1:0] r_cnt;
  logic             r_last_exit;

  logic w_entry_ok;
  logic w_exit_ok;
  logic w_pick_entry;

  assign full         = (occupancy == c_capacity);
  assign w_entry_ok   = entry_req && !full;
  assign w_exit_ok    = exit_req && (occupancy != '0);
  // On a tie the lane not served last wins; a lone eligible lane always wins.
  assign w_pick_entry = w_entry_ok && (!w_exit_ok || r_last_exit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_exit <= 1'b1;
      open_cmd    <= 1'b0;
      close_cmd   <= 1'b0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      occupancy   <= '0;
      fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_entry_ok || w_exit_ok) begin
            r_state     <= S_OPEN_WAIT;
            open_cmd    <= 1'b1;
            entry_grant <= w_pick_entry;
            exit_grant  <= !w_pick_entry;
            if (w_entry_ok && w_exit_ok) begin
              r_last_exit <= !w_pick_entry;
            end
          end
        end
        S_OPEN_WAIT: begin
          if (gate_ack) begin
            r_state  <= S_PASS_WAIT;
            open_cmd <= 1'b0;
            r_cnt    <= '0;
          end else if (r_cnt == c_ack_last) begin
            r_state     <= S_FAULT;
            open_cmd    <= 1'b0;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            fault       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PASS_WAIT: begin
          if (vehicle_passed || (r_cnt == c_pass_last)) begin
            r_state   <= S_CLOSE_WAIT;
            close_cmd <= 1'b1;
            r_cnt     <= '0;
            if (vehicle_passed) begin
              occupancy <= entry_grant ? occupancy + 1'b1 : occupancy - 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CLOSE_WAIT: begin
          if (gate_ack) begin
            r_state     <= S_IDLE;
            close_cmd   <= 1'b0;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt == c_ack_last) begin
            r_state     <= S_FAULT;
            close_cmd   <= 1'b0;
            entry_grant <= 1'b0;
            exit_grant  <= 1'b0;
            fault       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FAULT: begin
          open_cmd    <= 1'b0;
          close_cmd   <= 1'b0;
          entry_grant <= 1'b0;
          exit_grant  <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
